// File: rtl/trace_sequencer.sv
// Sequences a loadable table of target trace patterns, credits the first player whose
// traced bitmap covers the current target, and advances on a match, an empty target or a timeout.
module trace_sequencer #(
  parameter int PATTERN_W      = 16,
  parameter int NUM_TRACES     = 30,
  parameter int NUM_PLAYERS    = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int IDX_W          = $clog2(NUM_TRACES),
  parameter int SCORE_W        = $clog2(NUM_TRACES + 1)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             start,
  input  logic                             trace_screen_on,
  input  logic [NUM_PLAYERS-1:0]           player_en,
  input  logic [NUM_PLAYERS*PATTERN_W-1:0] traced_bus,
  input  logic                             load_we,
  input  logic [IDX_W-1:0]                 load_addr,
  input  logic [PATTERN_W-1:0]             load_data,
  output logic [PATTERN_W-1:0]             trace_to_display,
  output logic [PATTERN_W-1:0]             previous_trace_displayed,
  output logic [IDX_W-1:0]                 trace_count,
  output logic                             match_valid,
  output logic [2:0]                       match_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0]   score_bus,
  output logic [SCORE_W-1:0]               miss_count,
  output logic                             busy,
  output logic                             end_game
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRACES - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PATTERN_W-1:0] tbl_q [NUM_TRACES];

  logic [1:0]                           state_q, state_d;
  logic [IDX_W-1:0]                     count_q, count_d;
  logic [PATTERN_W-1:0]                 disp_q, disp_d;
  logic [PATTERN_W-1:0]                 prev_q, prev_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]                   miss_q, miss_d;
  logic [TMR_W-1:0]                     timer_q, timer_d;
  logic                                 mv_q, mv_d;
  logic [2:0]                           mp_q, mp_d;

  logic [NUM_PLAYERS-1:0] credit;
  logic                   hit;
  logic [2:0]             hit_p;
  logic [IDX_W-1:0]       nxt_idx;
  logic                   retire;

  // The table has no reset so a loaded game survives a mid-game reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && load_we && (32'(load_addr) < NUM_TRACES))
      tbl_q[load_addr] <= load_data;
  end

  // Descending scan so the lowest-index matching player ends up credited.
  always_comb begin
    credit = '0;
    hit    = 1'b0;
    hit_p  = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (player_en[p] &&
          ((traced_bus[p*PATTERN_W +: PATTERN_W] & disp_q) == disp_q)) begin
        credit    = '0;
        credit[p] = 1'b1;
        hit       = 1'b1;
        hit_p     = 3'(p);
      end
    end
  end

  assign nxt_idx = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    disp_d  = disp_q;
    prev_d  = prev_q;
    score_d = score_q;
    miss_d  = miss_q;
    timer_d = timer_q;
    mv_d    = 1'b0;
    mp_d    = mp_q;
    retire  = 1'b0;

    // A write in the same IDLE cycle takes precedence over start.
    if (start && !(state_q == S_IDLE && load_we)) begin
      state_d = S_SHOW;
      count_d = '0;
      disp_d  = tbl_q[0];
      prev_d  = '0;
      score_d = '0;
      miss_d  = '0;
      timer_d = '0;
    end else if (state_q == S_SHOW && trace_screen_on) begin
      // An all-zero target would match anyone, so it is dropped without credit.
      if (disp_q == '0) begin
        retire = 1'b1;
      end else if (hit) begin
        retire = 1'b1;
        mv_d   = 1'b1;
        mp_d   = hit_p;
        for (int p = 0; p < NUM_PLAYERS; p++)
          if (credit[p]) score_d[p] = sat_inc(score_q[p]);
      end else if (TIMEOUT_CYCLES != 0 && timer_q == TMR_LAST) begin
        retire = 1'b1;
        miss_d = sat_inc(miss_q);
      end else begin
        timer_d = timer_q + 1'b1;
      end

      if (retire) begin
        prev_d  = disp_q;
        timer_d = '0;
        if (count_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          count_d = nxt_idx;
          disp_d  = tbl_q[nxt_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      disp_q  <= '0;
      prev_q  <= '0;
      score_q <= '0;
      miss_q  <= '0;
      timer_q <= '0;
      mv_q    <= 1'b0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      disp_q  <= disp_d;
      prev_q  <= prev_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      timer_q <= timer_d;
      mv_q    <= mv_d;
      mp_q    <= mp_d;
    end
  end

  assign trace_to_display         = disp_q;
  assign previous_trace_displayed = prev_q;
  assign trace_count              = count_q;
  assign match_valid              = mv_q;
  assign match_player             = mp_q;
  assign score_bus                = score_q;
  assign miss_count               = miss_q;
  assign busy                     = (state_q == S_SHOW);
  assign end_game                 = (state_q == S_DONE);

endmodule
